gyro_sample_sched: RTL and testbench



---
 rtl/gyro_sample_sched.sv | 165 ++++++++++++++++
 tb/tb_gyro_sample_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_sample_sched.sv
// Sample scheduler between the gyro SPI reader and the tilt integrator: periodic read
// requests, start-up zero-rate bias calibration, and bias-corrected sample delivery.
module gyro_sample_sched #(
    parameter int SAMPLE_DIV = 50000,
    parameter int CAL_LOG2   = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RECAL,
    output logic               RD_REQ,
    input  logic               RD_ACK,
    input  logic signed [15:0] DX,
    input  logic signed [15:0] DY,
    input  logic signed [15:0] DZ,
    output logic signed [15:0] OX,
    output logic signed [15:0] OY,
    output logic signed [15:0] OZ,
    output logic               OVALID,
    output logic               CAL_DONE,
    output logic               OVERRUN,
    output logic               TIMEOUT_ERR,
    output logic [1:0]         STATE_DBG
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW = 16 + CAL_LOG2;

    // Handshake: RD_REQ stays high until RD_ACK is sampled high in the same cycle;
    // DX/DY/DZ are only taken in that cycle, and only while in S_REQ.
    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_REQ     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [WW-1:0]          wait_cnt_q;
    logic [CAL_LOG2-1:0]    cal_cnt_q;
    logic                   phase_run_q;
    logic [2:0][AW-1:0]     acc_q;
    logic [2:0][15:0]       bias_q;
    logic [2:0][15:0]       out_q;
    logic                   rd_req_q;
    logic                   ovalid_q;
    logic                   cal_done_q;
    logic                   overrun_q;
    logic                   timeout_err_q;

    logic                   tick;
    logic [2:0][15:0]       d_in;
    logic [2:0][AW-1:0]     acc_d;
    logic [2:0][15:0]       bias_d;
    logic [2:0][15:0]       out_d;

    // 17-bit difference, clamped to the 16-bit signed range on overflow.
    function automatic logic [15:0] sat_sub(input logic [15:0] d, input logic [15:0] b);
        logic [16:0] diff;
        diff = {d[15], d} - {b[15], b};
        if (diff[16] != diff[15])
            sat_sub = diff[16] ? 16'h8000 : 16'h7fff;
        else
            sat_sub = diff[15:0];
    endfunction

    assign tick = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
    assign d_in = {DZ, DY, DX};

    always_comb begin
        acc_d  = '0;
        bias_d = '0;
        out_d  = '0;
        for (int i = 0; i < 3; i++) begin
            acc_d[i]  = acc_q[i] + {{CAL_LOG2{d_in[i][15]}}, d_in[i]};
            bias_d[i] = acc_d[i][AW-1:CAL_LOG2];
            out_d[i]  = sat_sub(d_in[i], bias_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_q    <= '0;
            state_q       <= S_WAIT;
            wait_cnt_q    <= '0;
            cal_cnt_q     <= '0;
            phase_run_q   <= 1'b0;
            acc_q         <= '0;
            bias_q        <= '0;
            out_q         <= '0;
            rd_req_q      <= 1'b0;
            ovalid_q      <= 1'b0;
            cal_done_q    <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            if (RECAL) begin
                // Output samples are left as they were; everything else restarts calibration.
                state_q       <= S_WAIT;
                wait_cnt_q    <= '0;
                cal_cnt_q     <= '0;
                phase_run_q   <= 1'b0;
                acc_q         <= '0;
                bias_q        <= '0;
                rd_req_q      <= 1'b0;
                ovalid_q      <= 1'b0;
                cal_done_q    <= 1'b0;
                overrun_q     <= 1'b0;
                timeout_err_q <= 1'b0;
            end else begin
                ovalid_q <= 1'b0;
                if (tick && state_q != S_WAIT)
                    overrun_q <= 1'b1;
                case (state_q)
                    S_WAIT: begin
                        if (tick) begin
                            state_q    <= S_REQ;
                            rd_req_q   <= 1'b1;
                            wait_cnt_q <= '0;
                        end
                    end
                    S_REQ: begin
                        if (RD_ACK) begin
                            state_q  <= S_CAPTURE;
                            rd_req_q <= 1'b0;
                            if (!phase_run_q) begin
                                acc_q     <= acc_d;
                                cal_cnt_q <= cal_cnt_q + CAL_LOG2'(1);
                                if (&cal_cnt_q) begin
                                    bias_q      <= bias_d;
                                    cal_done_q  <= 1'b1;
                                    phase_run_q <= 1'b1;
                                end
                            end else begin
                                out_q    <= out_d;
                                ovalid_q <= 1'b1;
                            end
                        end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                            state_q       <= S_WAIT;
                            rd_req_q      <= 1'b0;
                            timeout_err_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end
                    S_CAPTURE: state_q <= S_WAIT;
                    default:   state_q <= S_WAIT;
                endcase
            end
        end
    end

    assign RD_REQ      = rd_req_q;
    assign OX          = out_q[0];
    assign OY          = out_q[1];
    assign OZ          = out_q[2];
    assign OVALID      = ovalid_q;
    assign CAL_DONE    = cal_done_q;
    assign OVERRUN     = overrun_q;
    assign TIMEOUT_ERR = timeout_err_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_gyro_sample_sched.sv
// Directed bench for gyro_sample_sched: table of run-phase samples plus hand-written
// sequences for calibration, timeout, overrun, RECAL and reset.
module tb_gyro_sample_sched;

    logic               clk = 1'b0;
    logic               rst, rst2, recal, ack, ack2;
    logic signed [15:0] dx, dy, dz;
    logic               rd_req, ovalid, cal_done, overrun, timeout_err;
    logic signed [15:0] ox, oy, oz;
    logic [1:0]         state_dbg;
    logic               rd_req2, ovalid2, cal_done2, overrun2, timeout_err2;
    logic signed [15:0] ox2, oy2, oz2;
    logic [1:0]         state_dbg2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gyro_sample_sched #(.SAMPLE_DIV(8), .CAL_LOG2(2), .TIMEOUT(4)) u_dut (
        .CLK(clk), .RST(rst), .RECAL(recal), .RD_REQ(rd_req), .RD_ACK(ack),
        .DX(dx), .DY(dy), .DZ(dz), .OX(ox), .OY(oy), .OZ(oz),
        .OVALID(ovalid), .CAL_DONE(cal_done), .OVERRUN(overrun),
        .TIMEOUT_ERR(timeout_err), .STATE_DBG(state_dbg)
    );

    gyro_sample_sched #(.SAMPLE_DIV(8), .CAL_LOG2(2), .TIMEOUT(20)) u_dut_ov (
        .CLK(clk), .RST(rst2), .RECAL(recal), .RD_REQ(rd_req2), .RD_ACK(ack2),
        .DX(dx), .DY(dy), .DZ(dz), .OX(ox2), .OY(oy2), .OZ(oz2),
        .OVALID(ovalid2), .CAL_DONE(cal_done2), .OVERRUN(overrun2),
        .TIMEOUT_ERR(timeout_err2), .STATE_DBG(state_dbg2)
    );

    typedef struct {
        logic signed [15:0] dx, dy, dz;
        logic signed [15:0] ox, oy, oz;
    } vec_t;

    vec_t run_tab[4];
    logic signed [15:0] cal_dx[4];
    logic signed [15:0] cal_dy[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!rd_req && n < 40) begin
            step();
            n++;
        end
        chk("req_seen", int'(rd_req), 1);
    endtask

    // Waits for a request, acks it dly cycles after it is first seen, and leaves the
    // bench in the cycle after the ack (CAPTURE, where OVALID would be high).
    task automatic do_read(input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic signed [15:0] z, input int dly);
        int n;
        wait_req(n);
        for (int k = 0; k < dly; k++) begin
            chk("req_held", int'(rd_req), 1);
            step();
        end
        ack = 1'b1; dx = x; dy = y; dz = z;
        step();
        ack = 1'b0;
        chk("req_fall", int'(rd_req), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_req"}, int'(rd_req), 0);
        chk({tag, "_ox"}, int'(ox), 0);
        chk({tag, "_oy"}, int'(oy), 0);
        chk({tag, "_oz"}, int'(oz), 0);
        chk({tag, "_ovalid"}, int'(ovalid), 0);
        chk({tag, "_cal_done"}, int'(cal_done), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_timeout"}, int'(timeout_err), 0);
        chk({tag, "_state"}, int'(state_dbg), 0);
    endtask

    initial begin
        int n, hi;

        // Bias after calibration: x=(10+12+14+16)/4=13, y=floor(-10/4)=-3, z=100.
        cal_dx = '{16'sd10, 16'sd12, 16'sd14, 16'sd16};
        cal_dy = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
        run_tab[0] = '{16'sd20, 16'sd0, 16'sd100, 16'sd7, 16'sd3, 16'sd0};
        run_tab[1] = '{16'sd32767, 16'sd32767, 16'sh8000, 16'sd32754, 16'sd32767, 16'sh8000};
        run_tab[2] = '{16'sh8000, 16'sh8000, 16'sd32767, 16'sh8000, -16'sd32765, 16'sd32667};
        run_tab[3] = '{16'sd0, 16'sd0, 16'sd0, -16'sd13, 16'sd3, -16'sd100};

        rst = 1'b1; rst2 = 1'b1; recal = 1'b0; ack = 1'b0; ack2 = 1'b0;
        dx = '0; dy = '0; dz = '0;
        repeat (3) step();
        check_all_zero("reset");

        rst = 1'b0;
        wait_req(n);
        chk("first_req_latency", n, 8);

        // Calibration: no OVALID, CAL_DONE only after the 4th ack.
        for (int i = 0; i < 4; i++) begin
            do_read(cal_dx[i], cal_dy[i], 16'sd100, 2);
            chk("cal_no_ovalid", int'(ovalid), 0);
            chk("cal_done", int'(cal_done), (i == 3) ? 1 : 0);
        end

        for (int i = 0; i < 4; i++) begin
            do_read(run_tab[i].dx, run_tab[i].dy, run_tab[i].dz, 2);
            chk("run_ovalid", int'(ovalid), 1);
            chk("run_ox", int'(ox), int'(run_tab[i].ox));
            chk("run_oy", int'(oy), int'(run_tab[i].oy));
            chk("run_oz", int'(oz), int'(run_tab[i].oz));
            step();
            chk("run_ovalid_low", int'(ovalid), 0);
            chk("run_ox_hold", int'(ox), int'(run_tab[i].ox));
        end

        // Ack outside REQ is ignored.
        ack = 1'b1; dx = 16'sd1234;
        step();
        ack = 1'b0;
        chk("stray_ack_ovalid", int'(ovalid), 0);
        chk("stray_ack_ox", int'(ox), -13);

        // Timeout in RUN: request high exactly 4 cycles.
        wait_req(n);
        chk("to_before", int'(timeout_err), 0);
        hi = 1;
        step();
        while (rd_req && hi < 20) begin
            hi++;
            step();
        end
        chk("to_req_cycles", hi, 4);
        chk("to_err", int'(timeout_err), 1);
        chk("to_no_overrun", int'(overrun), 0);

        // RECAL mid-REQ with a coinciding ack.
        wait_req(n);
        chk("recal_pre_cal_done", int'(cal_done), 1);
        recal = 1'b1; ack = 1'b1; dx = 16'sd500;
        step();
        recal = 1'b0; ack = 1'b0;
        chk("recal_req_low", int'(rd_req), 0);
        chk("recal_cal_done", int'(cal_done), 0);
        chk("recal_timeout_clr", int'(timeout_err), 0);
        chk("recal_overrun", int'(overrun), 0);
        chk("recal_ovalid", int'(ovalid), 0);
        step();
        chk("recal_ovalid2", int'(ovalid), 0);

        // Recalibration with a timeout in the middle; bias x=-3, y=5, z=floor(-27/4)=-7.
        do_read(-16'sd3, 16'sd5, -16'sd7, 1);
        do_read(-16'sd3, 16'sd5, -16'sd7, 1);
        wait_req(n);
        hi = 0;
        while (rd_req && hi < 20) begin
            hi++;
            step();
        end
        chk("cal_to_cycles", hi, 4);
        chk("cal_to_err", int'(timeout_err), 1);
        chk("cal_to_cal_done", int'(cal_done), 0);
        do_read(-16'sd3, 16'sd5, -16'sd7, 1);
        chk("recal_3rd_cal_done", int'(cal_done), 0);
        do_read(-16'sd3, 16'sd5, -16'sd6, 1);
        chk("recal_4th_cal_done", int'(cal_done), 1);
        chk("recal_4th_ovalid", int'(ovalid), 0);

        do_read(16'sd32767, 16'sh8000, 16'sd0, 1);
        chk("sat_ovalid", int'(ovalid), 1);
        chk("sat_pos_ox", int'(ox), 32767);
        chk("sat_neg_oy", int'(oy), -32768);
        chk("neg_bias_oz", int'(oz), 7);

        // Reset mid-run, with RECAL asserted alongside.
        wait_req(n);
        rst = 1'b1; recal = 1'b1;
        step();
        rst = 1'b0; recal = 1'b0;
        check_all_zero("rst_mid");
        wait_req(n);
        chk("rst_req_latency", n, 8);

        // Overrun on the TIMEOUT=20 instance: ack 9 cycles after the request rises.
        rst2 = 1'b0;
        n = 0;
        while (!rd_req2 && n < 40) begin
            step();
            n++;
        end
        chk("ov_first_req", n, 8);
        for (int k = 0; k < 9; k++) begin
            chk("ov_req_held", int'(rd_req2), 1);
            step();
        end
        ack2 = 1'b1;
        step();
        ack2 = 1'b0;
        chk("ov_req_fall", int'(rd_req2), 0);
        chk("ov_overrun", int'(overrun2), 1);
        chk("ov_no_timeout", int'(timeout_err2), 0);
        n = 0;
        while (!rd_req2 && n < 40) begin
            step();
            n++;
        end
        chk("ov_next_req", n, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
